usb_desc_reader: RTL and testbench
==================================

USB_DESC_READER -- requirements
Module: usb_desc_reader

Interface
REQ-001 Parameter MAXPKT, default 64: control-endpoint max packet size in bytes; legal values are 8, 16, 32, 64.
REQ-002 Parameter HSSUPPORT, default 0: when 0, device-qualifier and other-speed requests SHALL stall.
REQ-003 Clock and reset: one clock `CLK`; reset `RESET_N` is synchronous and active-low.
REQ-004 CLK  in  1  clock; all logic SHALL be rising-edge.
REQ-005 RESET_N  in  1  synchronous active-low reset.
REQ-006 i_req_valid  in  1  GET_DESCRIPTOR request strobe.
REQ-007 o_req_ready  out  1  high only in IDLE.
REQ-008 i_desc_type  in  8  wValue high byte.
REQ-009 i_desc_index  in  8  wValue low byte.
REQ-010 i_wlength  in  16  host wLength.
REQ-011 i_hs_mode  in  1  1 = link is at high speed.
REQ-012 i_abort  in  1  new SETUP or bus reset; return to IDLE.
REQ-013 Descriptor table inputs, 16 bits each: i_desc_{dev,qual,fscfg,hscfg,oscfg,strlang,strvendor,strproduct,strserial}_addr and i_desc_{dev,qual,fscfg,hscfg,strvendor,strproduct,strserial}_len.
REQ-014 i_descrom_have_strings  in  1  the string descriptors are present in ROM.
REQ-015 o_descrom_raddr  out  16  descriptor ROM address.
REQ-016 i_descrom_rdat  in  8  ROM data, combinational from o_descrom_raddr.
REQ-017 o_tx_data  out  8  descriptor byte.
REQ-018 o_tx_valid  out  1  o_tx_data is valid.
REQ-019 i_tx_ready  in  1  the endpoint takes the byte.
REQ-020 o_tx_last  out  1  final byte of the current packet.
REQ-021 o_tx_zlp  out  1  one-cycle pulse requesting a zero-length packet.
REQ-022 i_pkt_done  in  1  one-cycle pulse: the host ACKed the packet.
REQ-023 o_stall  out  1  one-cycle pulse: the request is unsupported.
REQ-024 o_busy  out  1  high in any state other than IDLE.

Function
REQ-025 The FSM SHALL have states IDLE, LOOKUP, SEND, PKT_WAIT, ZLP, ZLP_WAIT.
REQ-026 IDLE: when i_req_valid and o_req_ready are both high, the block SHALL latch type, index, wLength and hs_mode, then go to LOOKUP.
REQ-027 LOOKUP selects base address and descriptor length from type:
  - type 1: dev.
  - type 2: hscfg if latched hs_mode, else fscfg.
  - type 3: index 0 = strlang (length 4), 1 = vendor, 2 = product, 3 = serial.
  - type 6: qual.
  - type 7: the opposite speed config from type 2.
REQ-028 LOOKUP SHALL pulse o_stall and return to IDLE in any of these cases:
  - type not in the set above;
  - string index greater than 3;
  - type 3 with i_descrom_have_strings=0;
  - type 6 or 7 with HSSUPPORT=0;
  - selected descriptor length is 0.
REQ-029 Transfer length SHALL be xfer = min(wLength, descriptor length), computed unsigned in 16 bits.
REQ-030 If xfer is 0, LOOKUP SHALL go to ZLP; otherwise it SHALL go to SEND with byte offset 0.
REQ-031 SEND: o_descrom_raddr = base + offset, 16-bit wrapping; the ROM byte SHALL be registered into o_tx_data with o_tx_valid=1.
REQ-032 The first byte SHALL be valid 2 cycles after request acceptance.
REQ-033 For type 7, the byte at offset 1 SHALL be forced to 8'h07.
REQ-034 o_tx_data and o_tx_valid SHALL hold until i_tx_ready; each accepted byte increments offset and the packet count.
REQ-035 Sustained throughput SHALL be one byte per cycle while i_tx_ready is high.
REQ-036 o_tx_last SHALL be 1 when the packet count equals MAXPKT-1 or when offset equals xfer-1.
REQ-037 Once the byte with o_tx_last=1 is accepted, the FSM SHALL go to PKT_WAIT with o_tx_valid=0.
REQ-038 PKT_WAIT: on i_pkt_done, the packet count SHALL clear. Next state:
  - SEND, if offset < xfer;
  - ZLP, if offset == xfer, xfer < wLength and xfer mod MAXPKT == 0;
  - IDLE otherwise.
REQ-039 ZLP: o_tx_zlp SHALL pulse for one cycle, then the FSM goes to ZLP_WAIT; ZLP_WAIT goes to IDLE on i_pkt_done.
REQ-040 i_abort has highest priority: from any state, the next state SHALL be IDLE with o_tx_valid=0, and no stall or zlp pulse.
REQ-041 i_pkt_done outside PKT_WAIT and ZLP_WAIT SHALL be ignored.
REQ-042 i_req_valid outside IDLE SHALL be ignored.

Reset
REQ-043 While RESET_N=0 at a CLK edge, the next state SHALL be:
  - state IDLE;
  - o_tx_valid, o_tx_last, o_tx_zlp, o_stall, o_busy = 0;
  - o_tx_data = 8'h00, o_descrom_raddr = 16'h0000;
  - offset, packet count and latched request fields = 0.
REQ-044 o_req_ready SHALL be 1 from the first cycle after reset release.
REQ-045 Reset mid-transfer SHALL discard the transfer without a stall or zlp pulse.

Structure
REQ-046 A shared package usb_desc_pkg SHALL hold:
  - descriptor-type constants DEV=1, CFG=2, STR=3, QUAL=6, OSCFG=7;
  - the FSM state enum;
  - the MAXPKT legality check.
REQ-047 The block SHALL have one sub-module, usb_desc_lookup: combinational type/index to {base, len, stall}.

Verification
REQ-048 MAXPKT=64, type 1, wLength 64 -> 18 bytes starting 12 01 00 02, o_tx_last on byte 18, then IDLE after i_pkt_done; no zlp.
REQ-049 MAXPKT=8, hs_mode=0, type 2, wLength 255 -> packets of 8,8,8,8,7 bytes (39 total); byte 3 = 8'h27.
REQ-050 MAXPKT=8, HSSUPPORT=1, hs_mode=1, type 2, wLength 64 -> 4 packets of 8 bytes, then a one-cycle o_tx_zlp pulse.
REQ-051 Type 3, index 4 -> o_stall pulse 2 cycles after acceptance, no o_tx_valid; HSSUPPORT=0 with type 6 -> stall.
REQ-052 Type 1, wLength 9, i_tx_ready toggling -> 9 bytes with o_tx_data stable while stalled; i_abort after byte 5 -> IDLE the next cycle, o_tx_valid low.

Source files
------------

// File: rtl/usb_desc_pkg.sv
// Shared definitions for the USB GET_DESCRIPTOR reader: descriptor types,
// FSM state encoding and the legality check for the control max packet size.
package usb_desc_pkg;

  // bDescriptorType values handled by the reader
  localparam logic [7:0] DEV   = 8'd1;
  localparam logic [7:0] CFG   = 8'd2;
  localparam logic [7:0] STR   = 8'd3;
  localparam logic [7:0] QUAL  = 8'd6;
  localparam logic [7:0] OSCFG = 8'd7;

  // The language-ID string descriptor always carries exactly one LANGID
  localparam logic [15:0] STRLANG_LEN = 16'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_SEND,
    S_PKT_WAIT,
    S_ZLP,
    S_ZLP_WAIT
  } usb_desc_state_e;

  // Control endpoint 0 only allows these max packet sizes
  function automatic bit maxpkt_legal(input int mp);
    return (mp == 8) || (mp == 16) || (mp == 32) || (mp == 64);
  endfunction

endpackage

// File: rtl/usb_desc_lookup.sv
// Combinational descriptor table lookup: maps descriptor type/index to the
// ROM base address and stored length, or flags the request as unsupported.
module usb_desc_lookup
  import usb_desc_pkg::*;
#(
  parameter int HSSUPPORT = 0
) (
  input  logic [7:0]  desc_type,
  input  logic [7:0]  desc_index,
  input  logic        hs_mode,
  input  logic        have_strings,
  input  logic [15:0] dev_addr,
  input  logic [15:0] qual_addr,
  input  logic [15:0] fscfg_addr,
  input  logic [15:0] hscfg_addr,
  input  logic [15:0] oscfg_addr,
  input  logic [15:0] strlang_addr,
  input  logic [15:0] strvendor_addr,
  input  logic [15:0] strproduct_addr,
  input  logic [15:0] strserial_addr,
  input  logic [15:0] dev_len,
  input  logic [15:0] qual_len,
  input  logic [15:0] fscfg_len,
  input  logic [15:0] hscfg_len,
  input  logic [15:0] strvendor_len,
  input  logic [15:0] strproduct_len,
  input  logic [15:0] strserial_len,
  output logic [15:0] base,
  output logic [15:0] len,
  output logic        stall
);

  // Table select; a zero-length entry means the descriptor is absent
  always_comb begin
    base  = '0;
    len   = '0;
    stall = 1'b0;
    case (desc_type)
      DEV: begin
        base = dev_addr;
        len  = dev_len;
      end
      CFG: begin
        base = hs_mode ? hscfg_addr : fscfg_addr;
        len  = hs_mode ? hscfg_len  : fscfg_len;
      end
      STR: begin
        stall = !have_strings;
        case (desc_index)
          8'd0: begin base = strlang_addr;    len = STRLANG_LEN;    end
          8'd1: begin base = strvendor_addr;  len = strvendor_len;  end
          8'd2: begin base = strproduct_addr; len = strproduct_len; end
          8'd3: begin base = strserial_addr;  len = strserial_len;  end
          default: stall = 1'b1;
        endcase
      end
      QUAL: begin
        base  = qual_addr;
        len   = qual_len;
        stall = (HSSUPPORT == 0);
      end
      OSCFG: begin
        // Other-speed config is the config of the speed we are not running at;
        // its image lives at its own ROM address, its length is the opposite one
        base  = oscfg_addr;
        len   = hs_mode ? fscfg_len : hscfg_len;
        stall = (HSSUPPORT == 0);
      end
      default: stall = 1'b1;
    endcase
    if (len == 16'd0) stall = 1'b1;
  end

endmodule

// File: rtl/usb_desc_reader.sv
// GET_DESCRIPTOR engine: looks up a descriptor, streams min(wLength, length)
// bytes from ROM in MAXPKT-sized packets, and requests a trailing ZLP when a
// short transfer ends exactly on a packet boundary.
// Handshake: a byte transfers on a rising CLK edge where o_tx_valid and
// i_tx_ready are both high; o_tx_data/o_tx_last hold while o_tx_valid is high
// and i_tx_ready is low. Requests are taken when i_req_valid and o_req_ready
// are both high.
module usb_desc_reader
  import usb_desc_pkg::*;
#(
  parameter int MAXPKT    = 64,
  parameter int HSSUPPORT = 0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [7:0]      i_desc_type,
  input  logic [7:0]      i_desc_index,
  input  logic [15:0]     i_wlength,
  input  logic            i_hs_mode,
  input  logic            i_abort,
  input  logic [15:0]     i_desc_dev_addr,
  input  logic [15:0]     i_desc_qual_addr,
  input  logic [15:0]     i_desc_fscfg_addr,
  input  logic [15:0]     i_desc_hscfg_addr,
  input  logic [15:0]     i_desc_oscfg_addr,
  input  logic [15:0]     i_desc_strlang_addr,
  input  logic [15:0]     i_desc_strvendor_addr,
  input  logic [15:0]     i_desc_strproduct_addr,
  input  logic [15:0]     i_desc_strserial_addr,
  input  logic [15:0]     i_desc_dev_len,
  input  logic [15:0]     i_desc_qual_len,
  input  logic [15:0]     i_desc_fscfg_len,
  input  logic [15:0]     i_desc_hscfg_len,
  input  logic [15:0]     i_desc_strvendor_len,
  input  logic [15:0]     i_desc_strproduct_len,
  input  logic [15:0]     i_desc_strserial_len,
  input  logic            i_descrom_have_strings,
  output logic [15:0]     o_descrom_raddr,
  input  logic [7:0]      i_descrom_rdat,
  output logic [7:0]      o_tx_data,
  output logic            o_tx_valid,
  input  logic            i_tx_ready,
  output logic            o_tx_last,
  output logic            o_tx_zlp,
  input  logic            i_pkt_done,
  output logic            o_stall,
  output logic            o_busy,
  output usb_desc_state_e o_dbg_state
);

  if (!maxpkt_legal(MAXPKT)) begin : g_bad_maxpkt
    $error("usb_desc_reader: MAXPKT must be 8, 16, 32 or 64");
  end

  localparam logic [6:0]  PKT_LAST = 7'(MAXPKT - 1);
  localparam logic [15:0] PKT_MASK = 16'(MAXPKT - 1);

  usb_desc_state_e state_q, state_d;
  logic [7:0]  type_q, index_q, tx_data_q;
  logic [15:0] wlen_q, base_q, xfer_q, off_q, raddr_q;
  logic [6:0]  pkt_q;
  logic        hs_q, tx_valid_q, stall_q;
  logic [15:0] lk_base, lk_len, xfer_c, load_off;
  logic        lk_stall, accept, last, more, zlp_due;
  logic [7:0]  load_byte;

  usb_desc_lookup #(.HSSUPPORT(HSSUPPORT)) u_lookup (
    .desc_type       (type_q),
    .desc_index      (index_q),
    .hs_mode         (hs_q),
    .have_strings    (i_descrom_have_strings),
    .dev_addr        (i_desc_dev_addr),
    .qual_addr       (i_desc_qual_addr),
    .fscfg_addr      (i_desc_fscfg_addr),
    .hscfg_addr      (i_desc_hscfg_addr),
    .oscfg_addr      (i_desc_oscfg_addr),
    .strlang_addr    (i_desc_strlang_addr),
    .strvendor_addr  (i_desc_strvendor_addr),
    .strproduct_addr (i_desc_strproduct_addr),
    .strserial_addr  (i_desc_strserial_addr),
    .dev_len         (i_desc_dev_len),
    .qual_len        (i_desc_qual_len),
    .fscfg_len       (i_desc_fscfg_len),
    .hscfg_len       (i_desc_hscfg_len),
    .strvendor_len   (i_desc_strvendor_len),
    .strproduct_len  (i_desc_strproduct_len),
    .strserial_len   (i_desc_strserial_len),
    .base            (lk_base),
    .len             (lk_len),
    .stall           (lk_stall)
  );

  // raddr_q always points at the next byte to fetch (one ahead of o_tx_data),
  // so a byte can be reloaded on every accepted transfer. In LOOKUP the base
  // is presented directly so byte 0 is registered on the LOOKUP exit edge.
  assign xfer_c          = (wlen_q < lk_len) ? wlen_q : lk_len;
  assign accept          = tx_valid_q & i_tx_ready;
  assign last            = tx_valid_q & ((pkt_q == PKT_LAST) | (off_q == xfer_q - 16'd1));
  assign more            = off_q < xfer_q;
  assign zlp_due         = (xfer_q < wlen_q) && ((xfer_q & PKT_MASK) == 16'd0);
  assign load_off        = raddr_q - base_q;
  assign load_byte       = ((type_q == OSCFG) && (load_off == 16'd1)) ? 8'h07 : i_descrom_rdat;
  assign o_descrom_raddr = (state_q == S_LOOKUP) ? lk_base : raddr_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_valid      = tx_valid_q;
  assign o_tx_last       = last;
  assign o_stall         = stall_q;

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and state-derived outputs; abort overrides everything
  always_comb begin
    state_d     = state_q;
    o_req_ready = (state_q == S_IDLE);
    o_busy      = (state_q != S_IDLE);
    o_tx_zlp    = (state_q == S_ZLP) && !i_abort;
    o_dbg_state = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (i_req_valid) state_d = S_LOOKUP;
        S_LOOKUP: begin
          if (lk_stall)             state_d = S_IDLE;
          else if (xfer_c == 16'd0) state_d = S_ZLP;
          else                      state_d = S_SEND;
        end
        S_SEND:     if (accept && last) state_d = S_PKT_WAIT;
        S_PKT_WAIT: if (i_pkt_done) state_d = more ? S_SEND : (zlp_due ? S_ZLP : S_IDLE);
        S_ZLP:      state_d = S_ZLP_WAIT;
        S_ZLP_WAIT: if (i_pkt_done) state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Request latch, transfer counters and the output byte register
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      type_q     <= '0;
      index_q    <= '0;
      wlen_q     <= '0;
      hs_q       <= 1'b0;
      base_q     <= '0;
      xfer_q     <= '0;
      off_q      <= '0;
      pkt_q      <= '0;
      raddr_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (i_abort) begin
        tx_valid_q <= 1'b0;
        pkt_q      <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_req_valid) begin
              type_q  <= i_desc_type;
              index_q <= i_desc_index;
              wlen_q  <= i_wlength;
              hs_q    <= i_hs_mode;
            end
          end
          S_LOOKUP: begin
            off_q  <= '0;
            pkt_q  <= '0;
            base_q <= lk_base;
            xfer_q <= xfer_c;
            if (lk_stall) begin
              stall_q <= 1'b1;
            end else if (xfer_c != 16'd0) begin
              tx_data_q  <= i_descrom_rdat;
              tx_valid_q <= 1'b1;
              raddr_q    <= lk_base + 16'd1;
            end
          end
          S_SEND: begin
            if (accept) begin
              off_q <= off_q + 16'd1;
              pkt_q <= pkt_q + 7'd1;
            end
            if (accept && last) begin
              tx_valid_q <= 1'b0;
            end else if (!tx_valid_q || accept) begin
              tx_data_q  <= load_byte;
              tx_valid_q <= 1'b1;
              raddr_q    <= raddr_q + 16'd1;
            end
          end
          S_PKT_WAIT: if (i_pkt_done) pkt_q <= '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_desc_reader.sv
// Bench for usb_desc_reader: two instances (MAXPKT=64/HSSUPPORT=0 and
// MAXPKT=8/HSSUPPORT=1) share a descriptor ROM image; directed requests push
// expected bytes into a scoreboard that is drained as the DUT streams them.
module tb_usb_desc_reader;
  import usb_desc_pkg::*;

  localparam logic [15:0] T_DEV_A  = 16'h0000, T_DEV_L  = 16'd18;
  localparam logic [15:0] T_QUAL_A = 16'h0080, T_QUAL_L = 16'd10;
  localparam logic [15:0] T_FS_A   = 16'h0020, T_FS_L   = 16'd39;
  localparam logic [15:0] T_HS_A   = 16'h0050, T_HS_L   = 16'd32;
  localparam logic [15:0] T_OS_A   = 16'h00A0;
  localparam logic [15:0] T_LANG_A = 16'h00C0;
  localparam logic [15:0] T_VEN_A  = 16'h00C4, T_VEN_L  = 16'd10;
  localparam logic [15:0] T_PROD_A = 16'h00D0, T_PROD_L = 16'd12;
  localparam logic [15:0] T_SER_A  = 16'h00E0, T_SER_L  = 16'd0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [1:0]       req_valid, abort, tx_ready, pkt_done;
  logic [7:0]       desc_type, desc_index;
  logic [15:0]      wlength;
  logic             hs_mode, have_strings;
  wire  [1:0]       req_ready, tx_valid, tx_last, tx_zlp, stall, busy;
  wire  [1:0][7:0]  tx_data, rdat;
  wire  [1:0][15:0] raddr;
  wire  [1:0][2:0]  dbg_state;

  logic [7:0] rom [256];
  for (genvar g = 0; g < 2; g++) begin : g_rom
    assign rdat[g] = rom[raddr[g][7:0]] ^ raddr[g][15:8];
  end

  usb_desc_reader #(.MAXPKT(64), .HSSUPPORT(0)) u_dut0 (
    .CLK(clk), .RESET_N(reset_n), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_desc_type(desc_type), .i_desc_index(desc_index), .i_wlength(wlength),
    .i_hs_mode(hs_mode), .i_abort(abort[0]),
    .i_desc_dev_addr(T_DEV_A), .i_desc_qual_addr(T_QUAL_A), .i_desc_fscfg_addr(T_FS_A),
    .i_desc_hscfg_addr(T_HS_A), .i_desc_oscfg_addr(T_OS_A), .i_desc_strlang_addr(T_LANG_A),
    .i_desc_strvendor_addr(T_VEN_A), .i_desc_strproduct_addr(T_PROD_A),
    .i_desc_strserial_addr(T_SER_A), .i_desc_dev_len(T_DEV_L), .i_desc_qual_len(T_QUAL_L),
    .i_desc_fscfg_len(T_FS_L), .i_desc_hscfg_len(T_HS_L), .i_desc_strvendor_len(T_VEN_L),
    .i_desc_strproduct_len(T_PROD_L), .i_desc_strserial_len(T_SER_L),
    .i_descrom_have_strings(have_strings), .o_descrom_raddr(raddr[0]),
    .i_descrom_rdat(rdat[0]), .o_tx_data(tx_data[0]), .o_tx_valid(tx_valid[0]),
    .i_tx_ready(tx_ready[0]), .o_tx_last(tx_last[0]), .o_tx_zlp(tx_zlp[0]),
    .i_pkt_done(pkt_done[0]), .o_stall(stall[0]), .o_busy(busy[0]), .o_dbg_state(dbg_state[0])
  );

  usb_desc_reader #(.MAXPKT(8), .HSSUPPORT(1)) u_dut1 (
    .CLK(clk), .RESET_N(reset_n), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_desc_type(desc_type), .i_desc_index(desc_index), .i_wlength(wlength),
    .i_hs_mode(hs_mode), .i_abort(abort[1]),
    .i_desc_dev_addr(T_DEV_A), .i_desc_qual_addr(T_QUAL_A), .i_desc_fscfg_addr(T_FS_A),
    .i_desc_hscfg_addr(T_HS_A), .i_desc_oscfg_addr(T_OS_A), .i_desc_strlang_addr(T_LANG_A),
    .i_desc_strvendor_addr(T_VEN_A), .i_desc_strproduct_addr(T_PROD_A),
    .i_desc_strserial_addr(T_SER_A), .i_desc_dev_len(T_DEV_L), .i_desc_qual_len(T_QUAL_L),
    .i_desc_fscfg_len(T_FS_L), .i_desc_hscfg_len(T_HS_L), .i_desc_strvendor_len(T_VEN_L),
    .i_desc_strproduct_len(T_PROD_L), .i_desc_strserial_len(T_SER_L),
    .i_descrom_have_strings(have_strings), .o_descrom_raddr(raddr[1]),
    .i_descrom_rdat(rdat[1]), .o_tx_data(tx_data[1]), .o_tx_valid(tx_valid[1]),
    .i_tx_ready(tx_ready[1]), .o_tx_last(tx_last[1]), .o_tx_zlp(tx_zlp[1]),
    .i_pkt_done(pkt_done[1]), .o_stall(stall[1]), .o_busy(busy[1]), .o_dbg_state(dbg_state[1])
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom_at(input logic [15:0] a);
    return rom[a[7:0]] ^ a[15:8];
  endfunction

  // Expected byte stream: packet boundary every mp bytes, last byte of transfer
  task automatic push_expected(input int mp, input logic [15:0] base, input int xfer, input bit t7);
    logic [7:0] b;
    for (int i = 0; i < xfer; i++) begin
      b = rom_at(base + 16'(i));
      if (t7 && i == 1) b = 8'h07;
      exp_q.push_back(b);
      exp_last_q.push_back(((i % mp) == mp - 1) || (i == xfer - 1));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge one cycle after acceptance (DUT in LOOKUP)
  task automatic do_req(input int d, input logic [7:0] typ, input logic [7:0] idx,
                        input logic [15:0] wl, input logic hs);
    @(negedge clk);
    check("req_ready", 32'(req_ready[d]), 32'd1);
    desc_type = typ; desc_index = idx; wlength = wl; hs_mode = hs;
    req_valid[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("lookup_state", 32'(dbg_state[d]), 32'(S_LOOKUP));
    check("lookup_no_valid", 32'(tx_valid[d]), 32'd0);
  endtask

  // ready mode: 0 = always, 1 = toggling, 2 = random; abort_after < 0 disables abort
  task automatic drain(input int d, input int mode, input int abort_after);
    int cyc = 0;
    int acc = 0;
    logic r, lst;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       r = 1'b1;
        1:       r = cyc[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (abort_after >= 0 && acc == abort_after) begin
        tx_ready[d] = 1'b0;
        abort[d]    = 1'b1;
        @(negedge clk);
        abort[d] = 1'b0;
        check("abort_valid", 32'(tx_valid[d]), 32'd0);
        check("abort_idle", 32'(dbg_state[d]), 32'(S_IDLE));
        check("abort_no_stall", 32'(stall[d]), 32'd0);
        check("abort_no_zlp", 32'(tx_zlp[d]), 32'd0);
        exp_q.delete();
        exp_last_q.delete();
        break;
      end
      tx_ready[d] = r;
      check("tx_valid", 32'(tx_valid[d]), 32'd1);
      check("tx_data", 32'(tx_data[d]), 32'(exp_q[0]));
      check("tx_last", 32'(tx_last[d]), 32'(exp_last_q[0]));
      if (r) begin
        lst = exp_last_q[0];
        void'(exp_q.pop_front());
        void'(exp_last_q.pop_front());
        acc++;
        if (lst) begin
          @(negedge clk);
          tx_ready[d] = 1'b0;
          check("pkt_wait_valid", 32'(tx_valid[d]), 32'd0);
          check("pkt_wait_state", 32'(dbg_state[d]), 32'(S_PKT_WAIT));
          pkt_done[d] = 1'b1;
          @(negedge clk);
          pkt_done[d] = 1'b0;
        end
      end
    end
    tx_ready[d] = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic end_check(input int d, input bit exp_zlp);
    if (exp_zlp) begin
      check("zlp_pulse", 32'(tx_zlp[d]), 32'd1);
      check("zlp_state", 32'(dbg_state[d]), 32'(S_ZLP));
      @(negedge clk);
      check("zlp_one_cycle", 32'(tx_zlp[d]), 32'd0);
      check("zlp_wait_state", 32'(dbg_state[d]), 32'(S_ZLP_WAIT));
      pkt_done[d] = 1'b1;
      @(negedge clk);
      pkt_done[d] = 1'b0;
    end
    check("end_idle", 32'(busy[d]), 32'd0);
    check("end_no_zlp", 32'(tx_zlp[d]), 32'd0);
    check("end_no_valid", 32'(tx_valid[d]), 32'd0);
  endtask

  task automatic stall_req(input int d, input logic [7:0] typ, input logic [7:0] idx, input logic hs);
    do_req(d, typ, idx, 16'd64, hs);
    @(negedge clk);
    check("stall_pulse", 32'(stall[d]), 32'd1);
    check("stall_no_valid", 32'(tx_valid[d]), 32'd0);
    check("stall_idle", 32'(busy[d]), 32'd0);
    @(negedge clk);
    check("stall_one_cycle", 32'(stall[d]), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h01; rom[8'h02] = 8'h00; rom[8'h03] = 8'h02;
    rom[8'h20] = 8'h09; rom[8'h21] = 8'h02; rom[8'h22] = 8'h27; rom[8'h23] = 8'h00;
    rom[8'h50] = 8'h09; rom[8'h51] = 8'h02; rom[8'h52] = 8'h20; rom[8'h53] = 8'h00;
    reset_n = 1'b0; req_valid = '0; abort = '0; tx_ready = '0; pkt_done = '0;
    desc_type = '0; desc_index = '0; wlength = '0; hs_mode = 1'b0; have_strings = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(tx_valid[d]), 32'd0);
      check("rst_last", 32'(tx_last[d]), 32'd0);
      check("rst_zlp", 32'(tx_zlp[d]), 32'd0);
      check("rst_stall", 32'(stall[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_data", 32'(tx_data[d]), 32'h00);
      check("rst_raddr", 32'(raddr[d]), 32'h0000);
      check("rst_state", 32'(dbg_state[d]), 32'(S_IDLE));
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset0", 32'(req_ready[0]), 32'd1);
    check("ready_after_reset1", 32'(req_ready[1]), 32'd1);

    // device descriptor, MAXPKT 64: 18 bytes in one packet, no ZLP
    push_expected(64, T_DEV_A, 18, 1'b0);
    do_req(0, DEV, 8'd0, 16'd64, 1'b0);
    drain(0, 0, -1);
    end_check(0, 1'b0);

    // FS config, MAXPKT 8, wLength 255: 8,8,8,8,7 with random ready
    push_expected(8, T_FS_A, 39, 1'b0);
    do_req(1, CFG, 8'd0, 16'd255, 1'b0);
    drain(1, 2, -1);
    end_check(1, 1'b0);

    // HS config, 32 bytes < wLength 64 on a packet boundary: ZLP follows
    push_expected(8, T_HS_A, 32, 1'b0);
    do_req(1, CFG, 8'd0, 16'd64, 1'b1);
    drain(1, 0, -1);
    end_check(1, 1'b1);

    // exact multiple with xfer == wLength: no ZLP
    push_expected(8, T_FS_A, 16, 1'b0);
    do_req(1, CFG, 8'd0, 16'd16, 1'b0);
    drain(1, 0, -1);
    end_check(1, 1'b0);

    // other-speed config: byte 1 forced to 07
    push_expected(8, T_OS_A, 4, 1'b1);
    do_req(1, OSCFG, 8'd0, 16'd4, 1'b0);
    drain(1, 0, -1);
    end_check(1, 1'b0);

    // vendor string, 10 bytes over two packets, toggling ready
    push_expected(8, T_VEN_A, 10, 1'b0);
    do_req(1, STR, 8'd1, 16'd255, 1'b0);
    drain(1, 1, -1);
    end_check(1, 1'b0);

    // unsupported requests
    stall_req(1, STR, 8'd4, 1'b0);
    stall_req(0, QUAL, 8'd0, 1'b0);
    stall_req(0, STR, 8'd3, 1'b0);
    stall_req(0, 8'h09, 8'd0, 1'b0);
    have_strings = 1'b0;
    stall_req(1, STR, 8'd0, 1'b0);
    have_strings = 1'b1;

    // wLength 9 with toggling ready
    push_expected(64, T_DEV_A, 9, 1'b0);
    do_req(0, DEV, 8'd0, 16'd9, 1'b0);
    drain(0, 1, -1);
    end_check(0, 1'b0);

    // abort after five accepted bytes
    push_expected(64, T_DEV_A, 18, 1'b0);
    do_req(0, DEV, 8'd0, 16'd64, 1'b0);
    drain(0, 0, 5);

    // reset mid-transfer discards quietly
    do_req(0, DEV, 8'd0, 16'd64, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", 32'(tx_valid[0]), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(tx_valid[0]), 32'd0);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_stall", 32'(stall[0]), 32'd0);
    check("midrst_zlp", 32'(tx_zlp[0]), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready[0]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
